// File: rtl/stack_text_renderer.sv
// stack_text_renderer: hex text overlay of a stack snapshot for the VGA calculator.
// Three-stage pixel pipeline around an external 8x16 font ROM; snapshot latched per frame.
module stack_text_renderer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned ORIGIN_X = 0,
    parameter int unsigned ORIGIN_Y = 0,
    parameter logic [11:0] FG       = 12'hfff,
    parameter logic [11:0] BG       = 12'h000,
    parameter logic [11:0] ERR_FG   = 12'hf00
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    input  logic                        in_display_area,
    input  logic                        frame_start,
    input  logic [DEPTH*4*DIGITS-1:0]   stack_data,
    input  logic [3:0]                  stack_count,
    input  logic                        error,
    output logic [10:0]                 font_addr,
    input  logic [7:0]                  font_data,
    output logic [11:0]                 vga_rgb
);

    localparam int unsigned EW     = 4 * DIGITS;
    localparam int unsigned SW     = DEPTH * EW;
    localparam logic [9:0]  OX     = 10'(ORIGIN_X);
    localparam logic [9:0]  OY     = 10'(ORIGIN_Y);
    localparam logic [3:0]  DEPTH4 = 4'(DEPTH);

    // Per-frame snapshot
    logic [SW-1:0] r_snap_data;
    logic [3:0]    r_snap_count;
    logic          r_snap_err;

    // Cell geometry and character selection
    logic [9:0]    w_dx;
    logic [9:0]    w_dy;
    logic [6:0]    w_cx;
    logic [5:0]    w_cy;
    logic          w_in_area;
    logic          w_err_row;
    logic [EW-1:0] w_entry;
    logic [3:0]    w_nib;
    logic [6:0]    w_char;
    logic [10:0]   w_addr;
    logic [11:0]   w_rgb;

    // Pipeline registers
    logic [10:0] r_font_addr;
    logic [2:0]  r_col1;
    logic        r_area1;
    logic        r_errl1;
    logic        r_de1;
    logic [7:0]  r_font_data;
    logic [2:0]  r_col2;
    logic        r_area2;
    logic        r_errl2;
    logic        r_de2;
    logic [11:0] r_vga_rgb;

    // Snapshot register: latch stack state on frame_start, count clamped to DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_data  <= '0;
            r_snap_count <= '0;
            r_snap_err   <= 1'b0;
        end else if (frame_start) begin
            r_snap_data  <= stack_data;
            r_snap_count <= (stack_count > DEPTH4) ? DEPTH4 : stack_count;
            r_snap_err   <= error;
        end
    end

    assign w_dx      = x - OX;
    assign w_dy      = y - OY;
    assign w_cx      = w_dx[9:3];
    assign w_cy      = w_dy[9:4];
    assign w_in_area = (x >= OX) && (w_cx <= 7'(DIGITS)) && (y >= OY) && (w_cy <= 6'(DEPTH));
    assign w_err_row = (w_cy == 6'(DEPTH));

    // Character code for the current cell
    always_comb begin
        w_entry = '0;
        w_nib   = '0;
        w_char  = 7'h20;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_cy == 6'(k)) w_entry = r_snap_data[k*EW +: EW];
        end
        for (int unsigned d = 1; d <= DIGITS; d++) begin
            if (w_cx == 7'(d)) w_nib = w_entry[4*(DIGITS-d) +: 4];
        end
        if (w_err_row) begin
            if (r_snap_err) begin
                case (w_cx)
                    7'd0:       w_char = 7'h45;
                    7'd1, 7'd2: w_char = 7'h52;
                    default:    w_char = 7'h20;
                endcase
            end
        end else if (w_cx == 7'd0) begin
            if ((w_cy == 6'd0) && (r_snap_count != 4'd0)) w_char = 7'h3E;
        end else if (w_cy < {2'b00, r_snap_count}) begin
            w_char = (w_nib < 4'd10) ? (7'h30 + 7'(w_nib)) : (7'h37 + 7'(w_nib));
        end
    end

    assign w_addr = w_in_area ? {w_char, w_dy[3:0]} : 11'd0;

    // Pixel colour from the registered glyph row
    always_comb begin
        w_rgb = 12'h000;
        if (r_de2 && r_area2) begin
            if (r_font_data[3'(3'd7 - r_col2)]) w_rgb = r_errl2 ? ERR_FG : FG;
            else                                w_rgb = BG;
        end
    end

    // Pipeline: S1 font address, S2 glyph row capture, S3 colour
    always_ff @(posedge clk) begin
        if (reset) begin
            r_font_addr <= '0;
            r_col1      <= '0;
            r_area1     <= 1'b0;
            r_errl1     <= 1'b0;
            r_de1       <= 1'b0;
            r_font_data <= '0;
            r_col2      <= '0;
            r_area2     <= 1'b0;
            r_errl2     <= 1'b0;
            r_de2       <= 1'b0;
            r_vga_rgb   <= 12'h000;
        end else begin
            r_font_addr <= w_addr;
            r_col1      <= w_dx[2:0];
            r_area1     <= w_in_area;
            r_errl1     <= w_in_area && w_err_row;
            r_de1       <= in_display_area;
            r_font_data <= font_data;
            r_col2      <= r_col1;
            r_area2     <= r_area1;
            r_errl2     <= r_errl1;
            r_de2       <= r_de1;
            r_vga_rgb   <= w_rgb;
        end
    end

    assign font_addr = r_font_addr;
    assign vga_rgb   = r_vga_rgb;

endmodule
